// File: rtl/chunked_adder_pkg.sv
// -----------------------------------------------------------------------------
// chunked_adder_pkg
// Shared types and helpers for the chunked add/subtract unit.
//   state_e      : controller states (IDLE, RUN, DONE)
//   calc_nchunk  : number of CHUNK-bit slices in a WIDTH-bit operand
//   calc_idx_w   : width of the slice index register (at least 1 bit)
// Optional feature macro used by the design: CHUNKED_ADDER_OVERFLOW_EN
// -----------------------------------------------------------------------------
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CHUNK-bit ripple-carry adder slice.
//   a_i, b_i     : CHUNK-bit addends
//   cin_i        : carry into bit 0
//   sum_o        : CHUNK-bit sum
//   cout_o       : carry out of the top bit
//   msb_cin_o    : carry into the top bit (used for signed overflow detection)
// Optional feature macro of the enclosing design: CHUNKED_ADDER_OVERFLOW_EN
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    // The ripple is written as a loop over a single carry variable so the
    // chain stays one combinational expression rather than a self-feeding vector.
    always_comb begin
        logic c;
        c         = cin_i;
        sum_o     = '0;
        msb_cin_o = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_cin_o = c;
            end
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
        end
        cout_o = c;
    end

endmodule

// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
// Multi-cycle add/subtract unit: processes CHUNK bits of a WIDTH-bit operand
// per clock, carrying between slices in a register.
//   clock, clear        : clock and synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   in_a, in_b          : operands
//   carry_in            : carry-in (add) / borrow-in (subtract)
//   sub                 : 0 = A+B+carry_in, 1 = A-B-carry_in
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out, carry_out      : result; for subtract carry_out=1 means no borrow
//   overflow            : signed overflow, present only when the macro
//                         CHUNKED_ADDER_OVERFLOW_EN is defined
// All outputs are driven from registers/state only.
// -----------------------------------------------------------------------------
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;       // already inverted for subtract
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q,  carry_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic               msb_cin_q, msb_cin_d;
`endif

    logic [31:0]        chunk_base;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic               chunk_msb_cin;
`endif

    assign chunk_base = 32'(idx_q) * 32'(CHUNK);
    assign chunk_a    = a_q[chunk_base +: CHUNK];
    assign chunk_b    = b_q[chunk_base +: CHUNK];

    adder_chunk #(
        .CHUNK     (CHUNK)
    ) u_adder_chunk (
        .a_i       (chunk_a),
        .b_i       (chunk_b),
        .cin_i     (carry_q),
        .sum_o     (chunk_sum),
        .cout_o    (chunk_cout),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        .msb_cin_o (chunk_msb_cin)
`else
        .msb_cin_o ()
`endif
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        msb_cin_d = msb_cin_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow; the inverted carry
                    // makes the final carry read as "no borrow".
                    a_d     = in_a;
                    b_d     = sub ? ~in_b : in_b;
                    carry_d = sub ? ~carry_in : carry_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[chunk_base +: CHUNK] = chunk_sum;
                carry_d   = chunk_cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                msb_cin_d = chunk_msb_cin;
`endif
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            msb_cin_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            msb_cin_q <= msb_cin_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = result_q;
    assign carry_out = carry_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    // Carry into vs out of the MSB of the last slice; forced low outside DONE.
    assign overflow  = (state_q == DONE) & (msb_cin_q ^ carry_q);
`endif

endmodule
